fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the RV32 pipeline: owns the PC register, issues word fetches to instruction memory over a valid/ready request plus valid-only response port, and presents `{pc, instruction}` to the decode/control stage through a registered IF/ID output. It honours a stall from downstream and a redirect (`pc_sel`/`pc_target`) from execute. It discards any in-flight fetch made stale by a redirect. The decode stage consumes `if_instr` directly as its `instruction` input.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  word-aligned fetch address (bits [1:0] always 0).
- `imem_req_ready`  in  1  memory accepts request when high with `imem_req_valid`.
- `imem_rsp_valid`  in  1  response word valid (exactly one per accepted request, in order, ≥1 cycle after acceptance).
- `imem_rsp_data`  in  32  fetched instruction.
- `pc_sel`  in  1  redirect strobe (taken branch/jump), single cycle.
- `pc_target`  in  32  redirect address; bits [1:0] ignored (forced 0).
- `stall`  in  1  decode cannot accept; IF/ID output must hold.
- `if_valid`  out  1  IF/ID holds a live instruction.
- `if_pc`  out  32  PC of `if_instr`.
- `if_instr`  out  32  instruction to decode; NOP (32'h0000_0013) when `if_valid`=0.

## Operation
- States: REQ (drive `imem_req_valid`=1, `imem_req_addr`=pc), WAIT (one request outstanding), HOLD (response buffered, waiting for IF/ID to free).
- REQ→WAIT on `imem_req_valid && imem_req_ready`; pc ← pc+4 on that edge (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- WAIT on `imem_rsp_valid`: if IF/ID free or being consumed (`!if_valid || !stall`), load IF/ID, → REQ; else capture into one-entry skid buffer, → HOLD.
- HOLD: when `!stall`, skid → IF/ID, → REQ.
- Consumption: decode takes instruction on any cycle with `if_valid && !stall`; if nothing new loads that edge, `if_valid` ← 0.
- Redirect (`pc_sel`=1), priority over stall and all other events:
  - pc ← `pc_target & ~3`; `if_valid` ← 0; skid cleared.
  - If in WAIT with response not arriving this cycle: set `discard`, stay in WAIT. The next response is dropped, then → REQ.
  - Response arriving in the same cycle as the redirect is dropped. No `discard` is set; → REQ.
  - REQ/HOLD → REQ.
  - A redirect in REQ with the request accepted that cycle: the request counts as outstanding, → WAIT with `discard`=1.
- Only one request outstanding at any time. `imem_req_valid`=0 outside REQ.

## Timing
- Reset values (async assert): `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `if_valid`=0, `if_pc`=RESET_PC, `if_instr`=NOP, state=REQ, `discard`=0, skid empty. First request is driven in the first cycle after `rst_n` deasserts.
- Fetch latency: response cycle t → `if_valid`/`if_instr` visible t+1.
- Redirect at cycle t → `imem_req_addr`=target from t+1, provided no stale response is pending.
- Peak throughput with 1-cycle memory: one instruction per 2 cycles.
- `imem_req_valid` stays asserted and `imem_req_addr` stays stable until accepted, except on redirect, where the address changes.
- Reset mid-WAIT: outstanding response ignored; the memory side is reset by the same `rst_n`.

## Structure
- Shared package `rv32_pkg`: `RESET_PC` default, `NOP_INSTR` (32'h0000_0013), fetch state enum {REQ, WAIT, HOLD}, XLEN=32.
- One sub-module: `fetch_skid_buf`, a one-entry `{pc, instr}` holding register with load/clear/valid. Everything else stays in `fetch_stage`.

## Test plan
- Reset release, memory always ready, 1-cycle response returning 32'h0000_0093 for each address → requests at 0x0, 0x4, 0x8…; `if_pc`/`if_instr` advance every 2 cycles; `if_instr`=NOP before the first response.
- `stall` held 5 cycles while a response arrives → IF/ID holds its value, the response goes to skid (HOLD), no new request; when `stall` drops, the skid word appears the next cycle with its correct pc.
- `pc_sel` with `pc_target`=0x0000_0103 while WAIT → response returning 3 cycles later is dropped; next request addr=0x0000_0100; `if_valid`=0 meanwhile.
- `pc_sel` coinciding with `imem_rsp_valid` and `stall`=1 → response dropped, `if_valid` cleared, skid empty, next request to target.
- `imem_req_ready` low for 4 cycles → `imem_req_addr` stable; PC at 0xFFFF_FFFC fetch → next address 0x0000_0000.
- `rst_n` asserted mid-WAIT → outputs return to reset values immediately (async); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 pipeline constants and fetch FSM state type.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding register for responses IF/ID cannot take yet.
module fetch_skid_buf
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      instr_o <= NOP_INSTR;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      instr_o <= instr_i;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch; owns the PC, fetches one word at a time, feeds IF/ID.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_target,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic            req_valid_q, discard_q, discard_d, if_valid_q, if_valid_d;
  logic            accept, skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem_rsp_data),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign accept         = req_valid_q && imem_req_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_valid_q ? if_instr_q : NOP_INSTR;

  always_comb begin
    state_d    = state_q;
    pc_d       = accept ? pc_q + XLEN'(4) : pc_q;
    req_pc_d   = accept ? pc_q : req_pc_q;
    discard_d  = discard_q;
    if_valid_d = if_valid_q && stall;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (pc_sel) begin
      // A request still in flight after the redirect leaves a stale response to drop.
      pc_d       = pc_target & ~XLEN'(3);
      if_valid_d = 1'b0;
      skid_clear = 1'b1;
      discard_d  = (state_q == WAIT && !imem_rsp_valid) || accept;
      state_d    = discard_d ? WAIT : REQ;
    end else begin
      case (state_q)
        REQ: state_d = accept ? WAIT : REQ;
        WAIT: if (imem_rsp_valid) begin
          state_d   = REQ;
          discard_d = 1'b0;
          if (!discard_q && (!if_valid_q || !stall)) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data;
          end else if (!discard_q) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: if (!stall) begin
          state_d    = REQ;
          if_valid_d = skid_valid;
          if_pc_d    = skid_pc;
          if_instr_d = skid_instr;
          skid_clear = 1'b1;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      discard_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= RESET_PC;
      if_instr_q  <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= state_d == REQ;
      discard_q   <= discard_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
    end
  end
endmodule
